// File: rtl/axis_pkt_hash_mon_pkg.sv
// Shared constants, the result record layout and lane helpers for the
// AXI-Stream packet hash monitor.
package axis_pkt_hash_mon_pkg;

   localparam logic [31:0] FNV_INIT_DEF  = 32'h811C9DC5;
   localparam logic [31:0] FNV_PRIME_DEF = 32'h01000193;
   localparam int          RES_W         = 48;

   typedef struct packed {
      logic [31:0] hash;
      logic [15:0] len;
   } res_t;

   function automatic logic [3:0] keep_popcount(input logic [7:0] keep);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, keep[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/axis_pkt_hash_mon_res_fifo.sv
// Synchronous result FIFO; a pop in the same cycle frees room for a push,
// and a push that cannot be stored is flagged so the caller can count it.
module hash_res_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             dropped,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             valid
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             pop_ok;
   logic             push_ok;
   logic             full;

   always_comb begin
      full    = (cnt_q == (AW+1)'(DEPTH));
      pop_ok  = pop && (cnt_q != '0);
      push_ok = push && (!full || pop_ok);
      dropped = push && !push_ok;
      valid   = (cnt_q != '0);
      rd_data = mem[rd_q];
      wr_d    = wr_q + AW'(push_ok);
      rd_d    = rd_q + AW'(pop_ok);
      cnt_d   = cnt_q;
      if (push_ok && !pop_ok) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_q] <= push_data;
      end
   end

endmodule

// File: rtl/axis_pkt_hash_mon.sv
// AXI-Stream pass-through skid slice with per-packet FNV hashing,
// length measurement, a result FIFO and traffic counters.
module axis_pkt_hash_mon
   import axis_pkt_hash_mon_pkg::*;
#(
   parameter int          DATA_W     = 32,
   parameter int          RES_DEPTH  = 8,
   parameter logic [31:0] HASH_INIT  = FNV_INIT_DEF,
   parameter logic [31:0] HASH_PRIME = FNV_PRIME_DEF
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic [DATA_W-1:0]   s_axis_tdata,
   input  logic [DATA_W/8-1:0] s_axis_tkeep,
   input  logic                s_axis_tvalid,
   input  logic                s_axis_tlast,
   output logic                s_axis_tready,
   output logic [DATA_W-1:0]   m_axis_tdata,
   output logic [DATA_W/8-1:0] m_axis_tkeep,
   output logic                m_axis_tvalid,
   output logic                m_axis_tlast,
   input  logic                m_axis_tready,
   input  logic                hash_mode,
   input  logic                clear,
   output logic [31:0]         res_hash,
   output logic [15:0]         res_len,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [31:0]         word_count,
   output logic [31:0]         pkt_count,
   output logic [31:0]         drop_count
);

   localparam int KW = DATA_W / 8;
   localparam int NW = DATA_W / 32;
   localparam int BW = DATA_W + KW + 1;

   logic [BW-1:0] out_q, out_d, skd_q, skd_d, in_beat;
   logic          out_vld_q, out_vld_d;
   logic          skd_vld_q, skd_vld_d;
   logic          rdy_q, rdy_d;
   logic          acc, m_pop;

   logic          in_pkt_q, in_pkt_d;
   logic          mode_q, mode_d, mode_eff;
   logic [31:0]   hash_q, hash_d, h;
   logic [15:0]   len_q, len_d, len_sat;
   logic [16:0]   len_sum;
   logic [7:0]    keep8;

   logic [31:0]   wc_q, wc_d, pc_q, pc_d, dc_q, dc_d;
   logic          push, dropped, res_pop;
   res_t          push_res, rd_res;

   assign in_beat = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
   assign acc     = s_axis_tvalid && rdy_q;
   assign m_pop   = out_vld_q && m_axis_tready;

   // Second register only fills while the output is stalled.
   always_comb begin
      out_d     = out_q;
      out_vld_d = out_vld_q;
      skd_d     = skd_q;
      skd_vld_d = skd_vld_q;
      if (skd_vld_q) begin
         if (m_pop) begin
            out_d     = skd_q;
            skd_vld_d = 1'b0;
         end
      end else begin
         if (m_pop) begin
            out_vld_d = 1'b0;
         end
         if (acc) begin
            if (!out_vld_q || m_pop) begin
               out_d     = in_beat;
               out_vld_d = 1'b1;
            end else begin
               skd_d     = in_beat;
               skd_vld_d = 1'b1;
            end
         end
      end
      rdy_d = !skd_vld_d;
   end

   always_comb begin
      keep8             = '0;
      keep8[KW-1:0]     = s_axis_tkeep;
      mode_eff          = in_pkt_q ? mode_q : hash_mode;
      len_sum           = {1'b0, len_q} + 17'(keep_popcount(keep8));
      len_sat           = len_sum[16] ? 16'hFFFF : len_sum[15:0];
      h                 = hash_q;
      if (mode_eff) begin
         for (int i = 0; i < KW; i++) begin
            if (s_axis_tkeep[i]) begin
               h = (h ^ {24'h0, s_axis_tdata[8*i +: 8]}) * HASH_PRIME;
            end
         end
      end else begin
         for (int j = 0; j < NW; j++) begin
            h = (h ^ s_axis_tdata[32*j +: 32]) * HASH_PRIME;
         end
      end
      in_pkt_d      = in_pkt_q;
      mode_d        = mode_q;
      hash_d        = hash_q;
      len_d         = len_q;
      push          = 1'b0;
      push_res.hash = h;
      push_res.len  = len_sat;
      if (acc) begin
         if (s_axis_tlast) begin
            in_pkt_d = 1'b0;
            hash_d   = HASH_INIT;
            len_d    = '0;
            push     = 1'b1;
         end else begin
            in_pkt_d = 1'b1;
            mode_d   = mode_eff;
            hash_d   = h;
            len_d    = len_sat;
         end
      end
   end

   // Clear has priority over any increment in the same cycle.
   always_comb begin
      wc_d = wc_q + 32'(acc);
      pc_d = pc_q + 32'(acc && s_axis_tlast);
      dc_d = dc_q;
      if (dropped && dc_q != 32'hFFFF_FFFF) begin
         dc_d = dc_q + 1'b1;
      end
      if (clear) begin
         wc_d = '0;
         pc_d = '0;
         dc_d = '0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_q     <= '0;
         out_vld_q <= 1'b0;
         skd_q     <= '0;
         skd_vld_q <= 1'b0;
         rdy_q     <= 1'b0;
         in_pkt_q  <= 1'b0;
         mode_q    <= 1'b0;
         hash_q    <= HASH_INIT;
         len_q     <= '0;
         wc_q      <= '0;
         pc_q      <= '0;
         dc_q      <= '0;
      end else begin
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
         skd_q     <= skd_d;
         skd_vld_q <= skd_vld_d;
         rdy_q     <= rdy_d;
         in_pkt_q  <= in_pkt_d;
         mode_q    <= mode_d;
         hash_q    <= hash_d;
         len_q     <= len_d;
         wc_q      <= wc_d;
         pc_q      <= pc_d;
         dc_q      <= dc_d;
      end
   end

   assign res_pop = res_valid && res_ready;

   hash_res_fifo #(
      .WIDTH (RES_W),
      .DEPTH (RES_DEPTH)
   ) u_res_fifo (
      .clk       (aclk),
      .rst_n     (aresetn),
      .push      (push),
      .push_data (push_res),
      .dropped   (dropped),
      .pop       (res_pop),
      .rd_data   (rd_res),
      .valid     (res_valid)
   );

   assign s_axis_tready = rdy_q;
   assign m_axis_tvalid = out_vld_q;
   assign m_axis_tdata  = out_q[DATA_W-1:0];
   assign m_axis_tkeep  = out_q[DATA_W +: KW];
   assign m_axis_tlast  = out_q[BW-1];
   assign res_hash      = rd_res.hash;
   assign res_len       = rd_res.len;
   assign word_count    = wc_q;
   assign pkt_count     = pc_q;
   assign drop_count    = dc_q;

endmodule
